// File: rtl/serializer_stream.sv
// Streaming parallel-to-serial converter with a one-word holding buffer, so that
// back-to-back words leave the block with no idle bit between them.
module serializer_stream #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             in_clock,
   input  logic             in_reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_ready,
   input  logic             in_enable,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } phase_t;

   phase_t           phase, phase_nxt;
   logic [WIDTH-1:0] sh, sh_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] hold;
   logic             hold_full, hold_full_nxt;
   logic             hold_load;
   logic             accept;
   logic [WIDTH-1:0] sh_shifted;

   assign out_ready  = in_reset_n & ~hold_full;
   assign accept     = in_valid & out_ready;
   assign sh_shifted = LSB_FIRST ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};

   // NOTE: every signal driven here is given its hold value first, so no path
   // through the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      phase_nxt     = phase;
      sh_nxt        = sh;
      cnt_nxt       = cnt;
      hold_full_nxt = hold_full;
      hold_load     = 1'b0;
      unique case (phase)
         IDLE: begin
            if (accept) begin
               sh_nxt    = in_data;
               cnt_nxt   = CNT_TOP;
               phase_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (in_enable && cnt == '0) begin
               if (hold_full) begin
                  sh_nxt        = hold;
                  cnt_nxt       = CNT_TOP;
                  hold_full_nxt = 1'b0;
               end else if (accept) begin
                  // Word offered in the last-bit cycle goes straight to the shifter.
                  sh_nxt  = in_data;
                  cnt_nxt = CNT_TOP;
               end else begin
                  phase_nxt = IDLE;
               end
            end else begin
               if (in_enable) begin
                  sh_nxt  = sh_shifted;
                  cnt_nxt = cnt - CW'(1);
               end
               if (accept) begin
                  hold_load     = 1'b1;
                  hold_full_nxt = 1'b1;
               end
            end
         end
         default: phase_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values computed before this edge, independent of statement order.
   always_ff @(posedge in_clock) begin
      if (!in_reset_n) begin
         phase     <= IDLE;
         sh        <= '0;
         cnt       <= '0;
         hold_full <= 1'b0;
      end else begin
         phase     <= phase_nxt;
         sh        <= sh_nxt;
         cnt       <= cnt_nxt;
         hold_full <= hold_full_nxt;
      end
   end

   // NOTE: hold is pure data qualified by hold_full, so it carries no reset.
   always_ff @(posedge in_clock) begin
      if (hold_load) hold <= in_data;
   end

   always_comb begin
      out_bit   = IDLE_LEVEL;
      out_valid = 1'b0;
      out_last  = 1'b0;
      if (phase == SHIFT) begin
         out_bit   = LSB_FIRST ? sh[0] : sh[WIDTH-1];
         out_valid = 1'b1;
         out_last  = (cnt == '0);
      end
   end

endmodule

// File: tb/tb_serializer_stream.sv
// Directed bench for serializer_stream: an MSB-first/idle-0 instance and an
// LSB-first/idle-1 instance sharing data, enable and reset.
module tb_serializer_stream;

   logic       clk;
   logic       rst_n;
   logic       a_in_valid, b_in_valid;
   logic [7:0] data;
   logic       enable;
   logic       a_ready, a_bit, a_valid, a_last;
   logic       b_ready, b_bit, b_valid, b_last;

   int n_cmp = 0;
   int n_bad = 0;

   serializer_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
      .in_clock  (clk),
      .in_reset_n(rst_n),
      .in_valid  (a_in_valid),
      .in_data   (data),
      .out_ready (a_ready),
      .in_enable (enable),
      .out_bit   (a_bit),
      .out_valid (a_valid),
      .out_last  (a_last)
   );

   serializer_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_b (
      .in_clock  (clk),
      .in_reset_n(rst_n),
      .in_valid  (b_in_valid),
      .in_data   (data),
      .out_ready (b_ready),
      .in_enable (enable),
      .out_bit   (b_bit),
      .out_valid (b_valid),
      .out_last  (b_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  w;
   logic [15:0] w16;

   initial begin
      rst_n = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0; data = '0; enable = 1'b0;

      // Reset state
      step(); step();
      check("rst_valid", a_valid, 1'b0);
      check("rst_last",  a_last,  1'b0);
      check("rst_bit",   a_bit,   1'b0);
      check("rst_ready", a_ready, 1'b0);
      check("rst_bit_b", b_bit,   1'b1);
      rst_n = 1'b1;
      #1;
      check("rel_ready", a_ready, 1'b1);
      check("rel_ready_b", b_ready, 1'b1);

      // Single word 0xA5, MSB first
      enable = 1'b1; a_in_valid = 1'b1; data = 8'hA5;
      step();
      a_in_valid = 1'b0;
      w = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         check("t1_bit",   a_bit,   w[7-i]);
         check("t1_valid", a_valid, 1'b1);
         check("t1_last",  a_last,  (i == 7));
         step();
      end
      check("t1_idle_valid", a_valid, 1'b0);
      check("t1_idle_bit",   a_bit,   1'b0);
      check("t1_idle_last",  a_last,  1'b0);

      // Back-to-back 0xA5, 0x3C through the holding buffer
      a_in_valid = 1'b1; data = 8'hA5;
      step();
      w16 = 16'hA53C;
      for (int i = 0; i < 16; i++) begin
         check("t2_bit",   a_bit,   w16[15-i]);
         check("t2_valid", a_valid, 1'b1);
         check("t2_last",  a_last,  (i == 7 || i == 15));
         check("t2_ready", a_ready, !(i >= 1 && i <= 7));
         if (i == 0) data = 8'h3C;
         else        a_in_valid = 1'b0;
         step();
      end
      check("t2_end_valid", a_valid, 1'b0);

      // LSB-first, idle level 1, word 0x01
      b_in_valid = 1'b1; data = 8'h01;
      step();
      b_in_valid = 1'b0;
      w = 8'h01;
      for (int i = 0; i < 8; i++) begin
         check("t3_bit",   b_bit,   w[i]);
         check("t3_valid", b_valid, 1'b1);
         check("t3_last",  b_last,  (i == 7));
         step();
      end
      check("t3_idle_valid", b_valid, 1'b0);
      check("t3_idle_bit",   b_bit,   1'b1);

      // Enable every third cycle, word 0xF0, second word 0x0F offered mid-word
      enable = 1'b0; a_in_valid = 1'b1; data = 8'hF0;
      step();
      w = 8'hF0;
      for (int c = 0; c < 24; c++) begin
         check("t4_bit",   a_bit,   w[7 - c/3]);
         check("t4_valid", a_valid, 1'b1);
         check("t4_last",  a_last,  (c >= 21));
         check("t4_ready", a_ready, (c <= 1));
         if (c == 1) begin
            a_in_valid = 1'b1;
            data = 8'h0F;
         end else begin
            a_in_valid = 1'b0;
         end
         enable = (c % 3 == 2);
         step();
      end
      enable = 1'b1;
      w = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         check("t4_hold_bit",   a_bit,   w[7-i]);
         check("t4_hold_valid", a_valid, 1'b1);
         check("t4_hold_ready", a_ready, 1'b1);
         step();
      end
      check("t4_end_valid", a_valid, 1'b0);

      // Reset mid-word with a second word held
      a_in_valid = 1'b1; data = 8'hA5;
      step();
      data = 8'h3C;
      step();
      a_in_valid = 1'b0;
      step();
      check("t5_pre_bit",   a_bit,   1'b1);
      check("t5_pre_valid", a_valid, 1'b1);
      check("t5_pre_ready", a_ready, 1'b0);
      rst_n = 1'b0; a_in_valid = 1'b1; data = 8'h77;
      #1;
      check("t5_rst_ready", a_ready, 1'b0);
      step();
      check("t5_valid", a_valid, 1'b0);
      check("t5_bit",   a_bit,   1'b0);
      check("t5_last",  a_last,  1'b0);
      check("t5_ready_low", a_ready, 1'b0);
      rst_n = 1'b1; a_in_valid = 1'b0;
      #1;
      check("t5_ready_rel", a_ready, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5_no_resume", a_valid, 1'b0);
      end

      // 0x81 offered exactly in the last-bit cycle of 0xFF
      a_in_valid = 1'b1; data = 8'hFF;
      step();
      a_in_valid = 1'b0;
      w16 = 16'hFF81;
      for (int i = 0; i < 16; i++) begin
         check("t6_bit",   a_bit,   w16[15-i]);
         check("t6_valid", a_valid, 1'b1);
         check("t6_last",  a_last,  (i == 7 || i == 15));
         if (i == 7) begin
            check("t6_ready", a_ready, 1'b1);
            a_in_valid = 1'b1;
            data = 8'h81;
         end else begin
            a_in_valid = 1'b0;
         end
         step();
      end
      check("t6_end_valid", a_valid, 1'b0);
      check("t6_end_bit",   a_bit,   1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
